// File: rtl/core_uart_tx.sv
// 8N1 UART transmitter fed by a small byte FIFO.
// Bytes are popped only from a registered non-empty FIFO, so each frame is followed by one idle cycle.
module core_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       OUTE,
  input  logic [7:0] OUTDATA,
  output logic       FULL,
  output logic       BUSY,
  output logic       TXD
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CntMax = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   Depth  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e        state_q, state_d;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          txd_q, txd_d;
  logic          push, pop, cnt_done;

  assign FULL     = (count_q == Depth);
  assign BUSY     = (count_q != '0) || (state_q != StIdle);
  assign TXD      = txd_q;
  assign push     = OUTE && !FULL;
  assign cnt_done = (cnt_q == CntMax);

  // Storage needs no reset; pointers and occupancy define validity.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q] <= OUTDATA;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        txd_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          shreg_d = mem[rd_ptr_q];
          state_d = StStart;
          txd_d   = 1'b0;
        end
      end
      StStart: begin
        if (cnt_done) begin
          cnt_d   = '0;
          bit_d   = '0;
          txd_d   = shreg_q[0];
          state_d = StData;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StData: begin
        if (cnt_done) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = StStop;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
            txd_d   = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StStop: begin
        if (cnt_done) begin
          cnt_d   = '0;
          txd_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
